sw_debounce: RTL and testbench



---
 rtl/sw_debounce.sv | 78 +++++++
 tb/tb_sw_debounce.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus per-bit stability counter.
// Produces a clean registered switch vector, a change strobe and a busy flag.
module sw_debounce #(
    parameter int                 G_WIDTH   = 4,
    parameter int                 G_CNT_MAX = 1000,
    parameter logic [G_WIDTH-1:0] G_RST_VAL = '0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [G_WIDTH-1:0] SW,
    output logic [G_WIDTH-1:0] D,
    output logic               CHG,
    output logic               BUSY
);

    localparam int CW = $clog2(G_CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(G_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [G_WIDTH-1:0]         sync1_q;
    logic [G_WIDTH-1:0]         sync2_q;
    logic [G_WIDTH-1:0]         d_q;
    logic [G_WIDTH-1:0]         d_d;
    logic [G_WIDTH-1:0][CW-1:0] cnt_q;
    logic [G_WIDTH-1:0][CW-1:0] cnt_d;
    logic [G_WIDTH-1:0]         commit;
    logic                       chg_q;
    logic                       chg_d;

    // Two-stage synchroniser; SW is only ever seen through sync2_q.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= G_RST_VAL;
            sync2_q <= G_RST_VAL;
        end else begin
            sync1_q <= SW;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit qualification: count consecutive disagreeing samples,
    // restart on any agreement, commit on the last count.
    always_comb begin
        d_d    = d_q;
        cnt_d  = cnt_q;
        commit = '0;
        for (int i = 0; i < G_WIDTH; i++) begin
            if (sync2_q[i] == d_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                d_d[i]    = sync2_q[i];
                cnt_d[i]  = '0;
                commit[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        chg_d = |commit;
    end

    // Debounced vector, counters and change strobe registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_q   <= G_RST_VAL;
            cnt_q <= '0;
            chg_q <= 1'b0;
        end else begin
            d_q   <= d_d;
            cnt_q <= cnt_d;
            chg_q <= chg_d;
        end
    end

    assign D    = d_q;
    assign CHG  = chg_q;
    assign BUSY = |cnt_q;

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: vector table, hand sequences and randomized run
// checked against a sample-history reference model.
module tb_sw_debounce;

    localparam int W   = 4;
    localparam int MAX = 4;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] SW = '0;
    logic [W-1:0] D;
    logic         CHG;
    logic         BUSY;

    sw_debounce #(
        .G_WIDTH  (W),
        .G_CNT_MAX(MAX),
        .G_RST_VAL('0)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .SW   (SW),
        .D    (D),
        .CHG  (CHG),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] sw;
        logic         rst_n;
        logic [W-1:0] d;
        logic         chg;
        logic         busy;
    } vec_t;

    vec_t tbl[$];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: SW values seen at each edge since reset,
    // and the synchronised sample each edge actually evaluated
    logic [W-1:0] swq[$];
    logic [W-1:0] s2q[$];
    logic [W-1:0] m_d;
    logic         m_chg;
    logic         m_busy;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        swq.delete();
        s2q.delete();
        m_d    = '0;
        m_chg  = 1'b0;
        m_busy = 1'b0;
    endfunction

    // trailing number of evaluated samples whose bit b differs from v
    function automatic int run_len(input int b, input logic v);
        int n = 0;
        for (int k = s2q.size() - 1; k >= 0; k--) begin
            if (s2q[k][b] == v) break;
            n++;
        end
        return n;
    endfunction

    function automatic void model_edge(input logic [W-1:0] sw);
        logic [W-1:0] s2;
        logic [W-1:0] nd;
        s2 = (swq.size() >= 2) ? swq[swq.size() - 2] : '0;
        swq.push_back(sw);
        s2q.push_back(s2);
        nd = m_d;
        m_chg = 1'b0;
        for (int b = 0; b < W; b++) begin
            if (run_len(b, m_d[b]) >= MAX) begin
                nd[b] = ~m_d[b];
                m_chg = 1'b1;
            end
        end
        m_d = nd;
        m_busy = 1'b0;
        for (int b = 0; b < W; b++)
            if (run_len(b, m_d[b]) > 0) m_busy = 1'b1;
    endfunction

    task automatic step(input logic [W-1:0] sw, input logic rst_n);
        SW = sw;
        RST_N = rst_n;
        if (!rst_n) model_reset();
        @(posedge CLK);
        if (rst_n) model_edge(sw);
        #1;
        chk("model_d", D, m_d);
        chk("model_chg", CHG, m_chg);
        chk("model_busy", BUSY, m_busy);
    endtask

    function automatic void add(input logic [W-1:0] sw, input logic r,
                                input logic [W-1:0] d, input logic c,
                                input logic b);
        vec_t v;
        v.sw = sw; v.rst_n = r; v.d = d; v.chg = c; v.busy = b;
        tbl.push_back(v);
    endfunction

    int           pulses;
    logic [W-1:0] next_d;
    logic [W-1:0] prev_sw;

    initial begin
        model_reset();
        // reset held with switches high
        for (int i = 0; i < 5; i++) add(4'hF, 0, 4'h0, 0, 0);
        for (int i = 0; i < 10; i++) add(4'h0, 1, 4'h0, 0, 0);
        // clean rising step on bit 0
        add(4'h1, 1, 4'h0, 0, 0); add(4'h1, 1, 4'h0, 0, 0);
        add(4'h1, 1, 4'h0, 0, 1); add(4'h1, 1, 4'h0, 0, 1);
        add(4'h1, 1, 4'h0, 0, 1); add(4'h1, 1, 4'h1, 1, 0);
        add(4'h1, 1, 4'h1, 0, 0);
        // clean falling step
        add(4'h0, 1, 4'h1, 0, 0); add(4'h0, 1, 4'h1, 0, 0);
        add(4'h0, 1, 4'h1, 0, 1); add(4'h0, 1, 4'h1, 0, 1);
        add(4'h0, 1, 4'h1, 0, 1); add(4'h0, 1, 4'h0, 1, 0);
        add(4'h0, 1, 4'h0, 0, 0);
        // bounce on bit 1: three samples then back
        add(4'h2, 1, 4'h0, 0, 0); add(4'h2, 1, 4'h0, 0, 0);
        add(4'h2, 1, 4'h0, 0, 1); add(4'h0, 1, 4'h0, 0, 1);
        add(4'h0, 1, 4'h0, 0, 1); add(4'h0, 1, 4'h0, 0, 0);
        add(4'h0, 1, 4'h0, 0, 0);
        // two bits at once: one pulse
        add(4'hA, 1, 4'h0, 0, 0); add(4'hA, 1, 4'h0, 0, 0);
        add(4'hA, 1, 4'h0, 0, 1); add(4'hA, 1, 4'h0, 0, 1);
        add(4'hA, 1, 4'h0, 0, 1); add(4'hA, 1, 4'hA, 1, 0);
        add(4'hA, 1, 4'hA, 0, 0);
        for (int i = 0; i < 5; i++) add(4'h0, 1, 4'hA, 0, i >= 2);
        add(4'h0, 1, 4'h0, 1, 0); add(4'h0, 1, 4'h0, 0, 0);
        // staggered bits 0 and 3
        add(4'h1, 1, 4'h0, 0, 0); add(4'h1, 1, 4'h0, 0, 0);
        add(4'h9, 1, 4'h0, 0, 1); add(4'h9, 1, 4'h0, 0, 1);
        add(4'h9, 1, 4'h0, 0, 1); add(4'h9, 1, 4'h1, 1, 1);
        add(4'h9, 1, 4'h1, 0, 1); add(4'h9, 1, 4'h9, 1, 0);
        add(4'h9, 1, 4'h9, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].sw, tbl[i].rst_n);
            chk($sformatf("tbl%0d_d", i), D, tbl[i].d);
            chk($sformatf("tbl%0d_chg", i), CHG, tbl[i].chg);
            chk($sformatf("tbl%0d_busy", i), BUSY, tbl[i].busy);
        end

        // async reset mid-qualification
        for (int i = 0; i < 8; i++) step(4'h0, 1);
        for (int i = 0; i < 4; i++) step(4'h1, 1);
        chk("pre_rst_busy", BUSY, 1'b1);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("async_d", D, 4'h0);
        chk("async_chg", CHG, 1'b0);
        chk("async_busy", BUSY, 1'b0);
        step(4'h1, 0);
        for (int i = 6; i <= 12; i++) begin
            step(4'h1, 1);
            if (i == 10) chk("rst_lat_d10", D, 4'h0);
        end
        chk("rst_lat_d12", D, 4'h1);

        // sweep all 16 values, 8 edges each
        for (int i = 0; i < 8; i++) step(4'h0, 1);
        chk("sweep_start", D, 4'h0);
        pulses = 0;
        next_d = 4'h1;
        for (int v = 0; v < 16; v++) begin
            for (int e = 0; e < 8; e++) begin
                step(4'(v), 1);
                if (CHG) begin
                    pulses++;
                    chk("sweep_order", D, next_d);
                    next_d = next_d + 4'h1;
                end
            end
        end
        chk("sweep_pulses", pulses, 15);
        chk("sweep_end", D, 4'hF);

        // randomized bouncing with occasional resets
        prev_sw = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 3)
                prev_sw = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 9) == 0)
                prev_sw[$urandom_range(0, W - 1)] ^= 1'b1;
            step(prev_sw, $urandom_range(0, 199) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
